// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush/redirect controller for the 5-stage RV32I
// pipeline. It combines the stall requests from the stages, sequences the
// branch redirects coming from ID, keeps stall and redirect counters, and
// raises a sticky error when a MEM access takes too long.
module pipeline_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_stall_req_i,
    input  logic              id_stall_req_i,
    input  logic              mem_stall_req_i,
    input  logic              branch_enable_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic [5:0]        stall_o,
    output logic              flush_ifid_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  redirect_count_o,
    output logic              err_o
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pend_addr;
    logic [5:0]        stall_vec;
    logic              accept;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  redir_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              err;

    // A branch from ID is only taken while nothing downstream of IF holds ID;
    // a frozen ID re-presents the same branch later.
    assign accept = branch_enable_i && !mem_stall_req_i && !id_stall_req_i;

    // Stall arbitration, MEM has priority over ID, ID over IF.
    always_comb begin
        stall_vec = '0;
        if (mem_stall_req_i) begin
            stall_vec = 6'b011111;
        end else if (id_stall_req_i) begin
            stall_vec = 6'b000111;
        end else if (if_stall_req_i) begin
            stall_vec = 6'b000011;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: park a branch in PEND while IF is still fetching.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (accept && if_stall_req_i) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (!if_stall_req_i && !mem_stall_req_i) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Capture the target of a branch that has to wait for IF.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_addr <= '0;
        end else if (state == RUN && accept && if_stall_req_i) begin
            pend_addr <= branch_addr_i;
        end
    end

    // Output logic: one-cycle redirect, either immediate or from PEND.
    always_comb begin
        redirect      = 1'b0;
        redirect_addr = '0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (accept && !if_stall_req_i) begin
                        redirect      = 1'b1;
                        redirect_addr = branch_addr_i;
                    end
                end
                PEND: begin
                    if (!if_stall_req_i && !mem_stall_req_i) begin
                        redirect      = 1'b1;
                        redirect_addr = pend_addr;
                    end
                end
                default: begin
                    redirect      = 1'b0;
                    redirect_addr = '0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (stall_vec != 6'b0 && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect && redir_cnt != '1) begin
                redir_cnt <= redir_cnt + 1'b1;
            end
        end
    end

    // MEM timeout: err sets on the edge where the run length reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else if (mem_stall_req_i) begin
            if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_cnt >= TMO_LAST) begin
                err <= 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Every output reads zero while reset is held.
    assign stall_o          = rst ? 6'b0 : stall_vec;
    assign redirect_o       = redirect;
    assign flush_ifid_o     = redirect;
    assign redirect_addr_o  = redirect_addr;
    assign stall_cycles_o   = rst ? '0 : stall_cnt;
    assign redirect_count_o = rst ? '0 : redir_cnt;
    assign err_o            = rst ? 1'b0 : err;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush/redirect controller for the 5-stage RV32I pipeline (pc, if, id, ex, mem, wb).
- Arbitrates stall requests from IF (fetch busy), ID (load-use hazard) and MEM (data access busy) into one per-stage stall vector.
- Sequences branch/jump redirects from ID, holding a redirect pending while IF is mid-fetch or MEM is stalled.
- Keeps performance counters and a sticky MEM-timeout error flag.

Parameters:
ADDR_W, 32, width of branch/redirect address
CNT_W, 32, width of the performance counters
MEM_TIMEOUT, 1024, consecutive mem_stall_req cycles after which err_o sets

Ports:
clk  in  1  clock
rst  in  1  reset
if_stall_req_i  in  1  IF fetch not complete
id_stall_req_i  in  1  ID load-use hazard (EX holds a load whose rd is an ID source)
mem_stall_req_i  in  1  MEM access not complete
branch_enable_i  in  1  ID resolved a taken branch/JAL/JALR this cycle
branch_addr_i  in  ADDR_W  target of that branch
stall_o  out  6  per-stage hold: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
flush_ifid_o  out  1  clear IF/ID register to a NOP (inst 0) at next edge
redirect_o  out  1  load pc with redirect_addr_o at next edge
redirect_addr_o  out  ADDR_W  redirect target
stall_cycles_o  out  CNT_W  cycles with stall_o != 0
redirect_count_o  out  CNT_W  redirects issued
err_o  out  1  sticky MEM timeout

Behaviour:
Reset:
- rst is synchronous, active-high.
- While rst=1, all outputs are 0 (stall_o=6'b0, redirect_addr_o=0).
- At the clock edge with rst=1: state<=RUN, pending address cleared, counters cleared, err_o cleared, timeout counter cleared.
- A pending redirect in flight when rst rises is discarded.

Stall arbitration (combinational, priority MEM > ID > IF):
- mem_stall_req_i=1 -> stall_o=6'b011111 (bubble into wb).
- else id_stall_req_i=1 -> stall_o=6'b000111 (bubble into ex).
- else if_stall_req_i=1 -> stall_o=6'b000011 (bubble into id).
- else stall_o=6'b000000.

State machine (2 states):
- RUN, accept condition: branch_enable_i=1 and mem_stall_req_i=0 and id_stall_req_i=0.
  - Accept with if_stall_req_i=0: same cycle redirect_o=1, flush_ifid_o=1, redirect_addr_o=branch_addr_i; stay RUN.
  - Accept with if_stall_req_i=1: latch branch_addr_i into pend_addr; go PEND; no redirect this cycle.
  - branch_enable_i while MEM or ID stalls: ignored. The frozen ID re-presents the branch, so it is not lost and not double-issued.
- PEND:
  - branch_enable_i is ignored.
  - Redirect fires in the first cycle with if_stall_req_i=0 and mem_stall_req_i=0: redirect_o=1, flush_ifid_o=1, redirect_addr_o=pend_addr; go RUN.
  - Otherwise hold PEND, redirect_o=0.
- redirect_o and flush_ifid_o are always asserted together, and for exactly one cycle per accepted branch.
- redirect_addr_o is 0 when redirect_o=0.

Counters:
- stall_cycles_o increments at each edge where stall_o != 0.
- redirect_count_o increments at each edge where redirect_o=1.
- Both saturate at all-ones (no wrap).

Timeout:
- A timeout counter increments while mem_stall_req_i=1 and clears when it is 0.
- When the counter reaches MEM_TIMEOUT, err_o<=1 and stays 1 until rst.
- The counter saturates at MEM_TIMEOUT.
- err_o does not alter stall behaviour.

Latency: stall and redirect outputs are combinational from the current inputs and state (0 cycles); counters and err_o are registered (1 cycle).

Test Plan:
- Reset: drive all requests =1 and branch_enable_i=1 with rst=1 for 2 cycles -> all outputs 0, counters 0; after rst drops, stall_o=6'b011111.
- Priority: if=1,id=1,mem=0 -> stall_o=6'b000111; add mem=1 -> 6'b011111; only if=1 -> 6'b000011; stall_cycles_o=3 after 3 edges.
- Immediate redirect: branch_enable_i=1, branch_addr_i=32'h0000_1040, no stalls -> same cycle redirect_o=1, flush_ifid_o=1, redirect_addr_o=32'h1040; redirect_count_o=1 next cycle.
- Pending redirect: branch to 32'h0000_2000 with if_stall_req_i=1 for 3 cycles, then mem_stall_req_i=1 for 1 more cycle -> redirect_o=0 throughout; fires on the first cycle with both low, addr 32'h2000, exactly one pulse; a second branch_enable_i during PEND produces no extra pulse.
- Ignored branch: branch_enable_i=1 with id_stall_req_i=1 for 2 cycles, then id=0 -> single redirect only in the third cycle; redirect_count_o=1.
- Timeout: MEM_TIMEOUT=4, mem_stall_req_i=1 for 3 cycles -> err_o=0; drop for 1 cycle, then hold 4 cycles -> err_o=1 after the 4th edge, still 1 after the request drops; rst clears it.
